// File: rtl/reorder_buffer_p.sv
// reorder_buffer_p: in-order commit ROB with writeback, flush, trap stop.
// Macro ROB_REPLAY_EN adds replay of the surviving range after a flush.
module reorder_buffer_p #(
    parameter int ID_LEN    = 6,
    parameter int WIDTH_EN  = 4,
    parameter int WIDTH_COM = 4,
    parameter int WIDTH_WB  = 4,
    parameter int PAYLOAD_W = 16,
    parameter int TRAP_MIN  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH_EN-1:0]  IN_enqValid,
    input  logic [ID_LEN:0]      IN_enqSqN     [WIDTH_EN],
    input  logic [PAYLOAD_W-1:0] IN_enqPayload [WIDTH_EN],
    input  logic [WIDTH_WB-1:0]  IN_wbValid,
    input  logic [ID_LEN:0]      IN_wbSqN      [WIDTH_WB],
    input  logic [3:0]           IN_wbFlags    [WIDTH_WB],
    input  logic                 IN_flushValid,
    input  logic [ID_LEN:0]      IN_flushSqN,
    input  logic                 IN_stall,
    output logic [WIDTH_COM-1:0] OUT_comValid,
    output logic [ID_LEN:0]      OUT_comSqN     [WIDTH_COM],
    output logic [PAYLOAD_W-1:0] OUT_comPayload [WIDTH_COM],
    output logic [3:0]           OUT_comFlags   [WIDTH_COM],
    output logic                 OUT_comReplay,
    output logic                 OUT_trapValid,
    output logic [ID_LEN:0]      OUT_trapSqN,
    output logic [3:0]           OUT_trapFlags,
    output logic [ID_LEN:0]      OUT_baseSqN,
    output logic [ID_LEN:0]      OUT_maxSqN
);
    localparam int LENGTH = 1 << ID_LEN;
    localparam logic [3:0] NX = 4'hF;

    typedef logic [ID_LEN:0] sqn_t;
    typedef enum logic [1:0] {RUN, TRAP_WAIT, REPLAY} state_t;

    function automatic logic younger(sqn_t a, sqn_t b);
        sqn_t d;
        d = a - b;
        return $signed(d) > 0;
    endfunction

    logic [LENGTH-1:0]    ent_valid;
    logic                 ent_msb     [LENGTH];
    logic [3:0]           ent_flags   [LENGTH];
    logic [PAYLOAD_W-1:0] ent_payload [LENGTH];

    state_t state, state_next;
    sqn_t   iter, iter_next, end_sqn, origin, retire_cnt;
    sqn_t   port_sqn [WIDTH_COM];
    logic [ID_LEN-1:0] port_idx [WIDTH_COM];
    logic [WIDTH_COM-1:0] com_valid_n, retire;
    logic   stop, com_replay_n, trap_valid_n;
    sqn_t   trap_sqn_n;
    logic [3:0] trap_flags_n;

    // Commit ports look at base in RUN and at the replay iterator in REPLAY.
    always_comb begin
        origin = (state == REPLAY) ? iter : OUT_baseSqN;
        for (int k = 0; k < WIDTH_COM; k++) begin
            port_sqn[k] = origin + sqn_t'(k);
            port_idx[k] = port_sqn[k][ID_LEN-1:0];
        end
    end

    // Next state, retire selection, trap detection and replay port validity.
    always_comb begin
        state_next   = state;
        iter_next    = iter;
        com_valid_n  = '0;
        retire       = '0;
        retire_cnt   = '0;
        stop         = 1'b0;
        com_replay_n = 1'b0;
        trap_valid_n = 1'b0;
        trap_sqn_n   = OUT_baseSqN;
        trap_flags_n = '0;
        if (IN_flushValid) begin
`ifdef ROB_REPLAY_EN
            state_next = REPLAY;
`else
            state_next = RUN;
`endif
        end else begin
            unique case (state)
                RUN: begin
                    if (!IN_stall) begin
                        for (int k = 0; k < WIDTH_COM; k++) begin
                            if (!stop && ent_valid[port_idx[k]] &&
                                ent_flags[port_idx[k]] != NX) begin
                                com_valid_n[k] = 1'b1;
                                retire[k]      = 1'b1;
                                retire_cnt     = sqn_t'(k + 1);
                                if (ent_flags[port_idx[k]] >= 4'(TRAP_MIN)) begin
                                    stop         = 1'b1;
                                    trap_valid_n = 1'b1;
                                    trap_sqn_n   = port_sqn[k];
                                    trap_flags_n = ent_flags[port_idx[k]];
                                    state_next   = TRAP_WAIT;
                                end
                            end else begin
                                stop = 1'b1;
                            end
                        end
                    end
                end
                TRAP_WAIT: state_next = TRAP_WAIT;
                REPLAY: begin
`ifdef ROB_REPLAY_EN
                    com_replay_n = 1'b1;
`endif
                    iter_next = iter + sqn_t'(WIDTH_COM);
                    for (int k = 0; k < WIDTH_COM; k++) begin
                        if (younger(port_sqn[k], end_sqn))
                            state_next = RUN;
                        else
                            com_valid_n[k] = ent_valid[port_idx[k]];
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    // State, entry array and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            ent_valid     <= '0;
            OUT_baseSqN   <= '0;
            OUT_maxSqN    <= sqn_t'(LENGTH - 1);
            iter          <= '0;
            end_sqn       <= '0;
            OUT_comValid  <= '0;
            OUT_comReplay <= 1'b0;
            OUT_trapValid <= 1'b0;
        end else begin
            state         <= state_next;
            OUT_comValid  <= com_valid_n;
            OUT_comReplay <= com_replay_n;
            OUT_trapValid <= trap_valid_n;
            OUT_trapSqN   <= trap_sqn_n;
            OUT_trapFlags <= trap_flags_n;
            for (int k = 0; k < WIDTH_COM; k++) begin
                OUT_comSqN[k]     <= port_sqn[k];
                OUT_comPayload[k] <= ent_payload[port_idx[k]];
                OUT_comFlags[k]   <= ent_flags[port_idx[k]];
            end
            for (int w = 0; w < WIDTH_WB; w++) begin
                if (IN_wbValid[w] && !(IN_flushValid &&
                    younger(IN_wbSqN[w], IN_flushSqN)))
                    ent_flags[IN_wbSqN[w][ID_LEN-1:0]] <= IN_wbFlags[w];
            end
            if (IN_flushValid) begin
                iter    <= OUT_baseSqN;
                end_sqn <= IN_flushSqN;
                for (int i = 0; i < LENGTH; i++) begin
                    if (ent_valid[i] &&
                        younger({ent_msb[i], ID_LEN'(i)}, IN_flushSqN))
                        ent_valid[i] <= 1'b0;
                end
            end else begin
                iter        <= iter_next;
                OUT_baseSqN <= OUT_baseSqN + retire_cnt;
                OUT_maxSqN  <= OUT_baseSqN + retire_cnt + sqn_t'(LENGTH - 1);
                for (int k = 0; k < WIDTH_COM; k++) begin
                    if (retire[k]) ent_valid[port_idx[k]] <= 1'b0;
                end
                for (int j = 0; j < WIDTH_EN; j++) begin
                    if (IN_enqValid[j]) begin
                        ent_valid[IN_enqSqN[j][ID_LEN-1:0]]   <= 1'b1;
                        ent_msb[IN_enqSqN[j][ID_LEN-1:0]]     <= IN_enqSqN[j][ID_LEN];
                        ent_payload[IN_enqSqN[j][ID_LEN-1:0]] <= IN_enqPayload[j];
                        ent_flags[IN_enqSqN[j][ID_LEN-1:0]]   <= NX;
                    end
                end
            end
        end
    end

    // Rename/execute protocol errors: overwrite, overflow, stale writeback.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < WIDTH_EN; j++) begin
                if (IN_enqValid[j] && !IN_flushValid) begin
                    assert (!ent_valid[IN_enqSqN[j][ID_LEN-1:0]]);
                    assert (!younger(IN_enqSqN[j], OUT_maxSqN));
                end
            end
            for (int w = 0; w < WIDTH_WB; w++) begin
                if (IN_wbValid[w])
                    assert (ent_valid[IN_wbSqN[w][ID_LEN-1:0]]);
            end
        end
    end
endmodule
